// File: rtl/select_rr_arbiter_wn_pkg.sv
// Shared types and helpers for the round-robin select arbiter.
package select_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Fill bit for the mux output when no requester is enabled.
  localparam logic SEL_DEFAULT_CASE_VAL = 1'b0;

  // First valid requester at or after ptr, wrapping modulo n (n <= 8).
  // Returns a one-hot vector, or zero when nothing is valid.
  function automatic logic [7:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [7:0]  r;
    logic        found;
    int unsigned idx;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && valid[idx[2:0]]) begin
        r[idx[2:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/select_rr_arbiter_wn_if.sv
// Requester bus and registered output port of the select arbiter.
interface select_rr_arbiter_wn_if #(
  parameter int unsigned dwidth = 32,
  parameter int unsigned nreq   = 4
);
  logic [nreq-1:0]        req_valid;
  logic [nreq-1:0]        req_lock;
  logic [nreq*dwidth-1:0] req_data;
  logic [nreq-1:0]        req_ready;
  logic                   o_valid;
  logic [dwidth-1:0]      o_data;
  logic                   o_ready;
  logic [nreq-1:0]        grant;
  logic                   busy;

  modport master (
    output req_valid, req_lock, req_data, o_ready,
    input  req_ready, o_valid, o_data, grant, busy
  );

  modport slave (
    input  req_valid, req_lock, req_data, o_ready,
    output req_ready, o_valid, o_data, grant, busy
  );
endinterface

// File: rtl/select_rr_arbiter_wn_onehot.sv
// One-hot AND-OR word selector; all-zero enable yields the default fill.
module select_onehot_n_wn import select_arb_pkg::*; #(
  parameter int unsigned dwidth = 32,
  parameter int unsigned nreq   = 4
) (
  input  logic [nreq-1:0]        en,
  input  logic [nreq*dwidth-1:0] din,
  output logic [dwidth-1:0]      dout
);

  // OR together every word masked by its enable bit.
  always_comb begin
    dout = {dwidth{SEL_DEFAULT_CASE_VAL}};
    for (int unsigned k = 0; k < nreq; k++) begin
      dout = dout | (din[k*dwidth +: dwidth] & {dwidth{en[k]}});
    end
  end

endmodule

// File: rtl/select_rr_arbiter_wn.sv
// Round-robin arbiter with locked multi-beat packets feeding one
// registered valid/ready output stage.
module select_rr_arbiter_wn import select_arb_pkg::*; #(
  parameter int unsigned dwidth = 32,
  parameter int unsigned nreq   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  select_rr_arbiter_wn_if.slave  bus
);

  localparam int unsigned pw = $clog2(nreq);

  arb_state_t        state_q, state_d;
  logic [pw-1:0]     ptr_q, ptr_d;
  logic [nreq-1:0]   grant_q, grant_d;
  logic [nreq-1:0]   sel;
  logic [7:0]        pick_full;
  logic [nreq-1:0]   pick;
  logic              stage_free;
  logic              accept;
  logic              last_beat;
  logic [dwidth-1:0] mux_out;
  logic              o_valid_q;
  logic [dwidth-1:0] o_data_q;
  logic              unused_pick;

  assign stage_free  = !o_valid_q || bus.o_ready;
  assign pick_full   = rr_pick(8'(bus.req_valid), 3'(ptr_q), nreq);
  assign pick        = pick_full[nreq-1:0];
  // Bits above nreq are always zero; folded here so they count as consumed.
  assign unused_pick = ^pick_full;

  // Winner selection, lock tracking and pointer advance.
  always_comb begin
    sel     = '0;
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (!reset && stage_free) begin
      if (state_q == ST_LOCKED) sel = grant_q & bus.req_valid;
      else                      sel = pick;
    end
    accept    = |sel;
    last_beat = ~|(sel & bus.req_lock);
    if (accept) begin
      if (!last_beat) begin
        state_d = ST_LOCKED;
        grant_d = sel;
      end else begin
        // sel equals the owner in LOCKED, so one path covers both states.
        state_d = ST_IDLE;
        grant_d = '0;
        for (int unsigned i = 0; i < nreq; i++) begin
          if (sel[i]) ptr_d = (i == nreq - 1) ? '0 : pw'(i + 1);
        end
      end
    end
  end

  // Arbiter state, owner and priority pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  select_onehot_n_wn #(
    .dwidth(dwidth),
    .nreq  (nreq)
  ) u_mux (
    .en  (sel),
    .din (bus.req_data),
    .dout(mux_out)
  );

  // Output stage: reload whenever free; a free stage with no winner clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else if (stage_free) begin
      o_valid_q <= accept;
      o_data_q  <= mux_out;
    end
  end

  assign bus.req_ready = sel;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_data    = o_data_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_select_rr_arbiter_wn.sv
// Directed bench for select_rr_arbiter_wn (nreq=4 and nreq=3 instances).
module tb_select_rr_arbiter_wn;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  select_rr_arbiter_wn_if #(.dwidth(32), .nreq(4)) bus4();
  select_rr_arbiter_wn_if #(.dwidth(32), .nreq(3)) bus3();

  select_rr_arbiter_wn #(.dwidth(32), .nreq(4)) dut4 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus4)
  );

  select_rr_arbiter_wn #(.dwidth(32), .nreq(3)) dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  lock;
    logic [7:0]  base;
    logic        ordy;
    logic [3:0]  ready;
    logic        ovalid;
    logic [31:0] odata;
    logic [3:0]  grant;
    logic        busy;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic [3:0] v, input logic [3:0] l, input logic [7:0] base,
                        input logic ordy);
    bus4.req_valid = v;
    bus4.req_lock  = l;
    for (int k = 0; k < 4; k++) bus4.req_data[k*32 +: 32] = 32'(base) + 32'(k);
    bus4.o_ready = ordy;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // valid lock base ordy | ready ovalid odata grant busy
    tbl[0]  = '{4'hF, 4'h0, 8'h10, 1'b1, 4'h1, 1'b1, 32'h10, 4'h0, 1'b0};
    tbl[1]  = '{4'hF, 4'h0, 8'h10, 1'b1, 4'h2, 1'b1, 32'h11, 4'h0, 1'b0};
    tbl[2]  = '{4'hF, 4'h0, 8'h10, 1'b1, 4'h4, 1'b1, 32'h12, 4'h0, 1'b0};
    tbl[3]  = '{4'hF, 4'h0, 8'h10, 1'b1, 4'h8, 1'b1, 32'h13, 4'h0, 1'b0};
    tbl[4]  = '{4'hF, 4'h0, 8'h10, 1'b1, 4'h1, 1'b1, 32'h10, 4'h0, 1'b0};
    tbl[5]  = '{4'hF, 4'h0, 8'h10, 1'b1, 4'h2, 1'b1, 32'h11, 4'h0, 1'b0};
    tbl[6]  = '{4'h7, 4'h4, 8'h9E, 1'b1, 4'h4, 1'b1, 32'hA0, 4'h4, 1'b1};
    tbl[7]  = '{4'h7, 4'h4, 8'h9F, 1'b1, 4'h4, 1'b1, 32'hA1, 4'h4, 1'b1};
    tbl[8]  = '{4'h7, 4'h0, 8'hA0, 1'b1, 4'h4, 1'b1, 32'hA2, 4'h0, 1'b0};
    tbl[9]  = '{4'hB, 4'h0, 8'h20, 1'b1, 4'h8, 1'b1, 32'h23, 4'h0, 1'b0};
    tbl[10] = '{4'h0, 4'h0, 8'h00, 1'b1, 4'h0, 1'b0, 32'h00, 4'h0, 1'b0};
    tbl[11] = '{4'h1, 4'h0, 8'h30, 1'b1, 4'h1, 1'b1, 32'h30, 4'h0, 1'b0};
    for (int r = 12; r <= 16; r++)
      tbl[r] = '{4'h3, 4'h0, 8'h40, 1'b0, 4'h0, 1'b1, 32'h30, 4'h0, 1'b0};
    tbl[17] = '{4'h3, 4'h0, 8'h40, 1'b1, 4'h2, 1'b1, 32'h41, 4'h0, 1'b0};
    tbl[18] = '{4'h0, 4'h0, 8'h00, 1'b1, 4'h0, 1'b0, 32'h00, 4'h0, 1'b0};
    tbl[19] = '{4'h1, 4'h1, 8'h50, 1'b1, 4'h1, 1'b1, 32'h50, 4'h1, 1'b1};
    tbl[20] = '{4'hE, 4'h0, 8'h60, 1'b1, 4'h0, 1'b0, 32'h00, 4'h1, 1'b1};
    tbl[21] = '{4'hF, 4'h0, 8'h70, 1'b1, 4'h1, 1'b1, 32'h70, 4'h0, 1'b0};

    // Reset values, with requests present so req_ready gating is exercised.
    reset = 1'b1;
    drive4(4'hF, 4'h0, 8'h10, 1'b1);
    bus3.req_valid = '0;
    bus3.req_lock  = '0;
    bus3.req_data  = '0;
    bus3.o_ready   = 1'b1;
    #2;
    chk("rst_ovalid", 32'(bus4.o_valid), 32'h0);
    chk("rst_odata", bus4.o_data, 32'h0);
    chk("rst_grant", 32'(bus4.grant), 32'h0);
    chk("rst_busy", 32'(bus4.busy), 32'h0);
    chk("rst_ready", 32'(bus4.req_ready), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table: rotation, locked packet, idle zeroing, backpressure, owner drop.
    for (int i = 0; i < 22; i++) begin
      drive4(tbl[i].valid, tbl[i].lock, tbl[i].base, tbl[i].ordy);
      #2;
      chk($sformatf("row%0d_ready", i), 32'(bus4.req_ready), 32'(tbl[i].ready));
      @(posedge clk); #1;
      chk($sformatf("row%0d_ovalid", i), 32'(bus4.o_valid), 32'(tbl[i].ovalid));
      chk($sformatf("row%0d_odata", i), bus4.o_data, tbl[i].odata);
      chk($sformatf("row%0d_grant", i), 32'(bus4.grant), 32'(tbl[i].grant));
      chk($sformatf("row%0d_busy", i), 32'(bus4.busy), 32'(tbl[i].busy));
    end

    // Reset mid-packet: pointer is at 1, requester 1 opens a locked packet.
    drive4(4'h2, 4'h2, 8'h80, 1'b1);
    #2;
    chk("lk_ready", 32'(bus4.req_ready), 32'h2);
    @(posedge clk); #1;
    chk("lk_busy", 32'(bus4.busy), 32'h1);
    chk("lk_grant", 32'(bus4.grant), 32'h2);
    chk("lk_odata", bus4.o_data, 32'h81);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ovalid", 32'(bus4.o_valid), 32'h0);
    chk("arst_busy", 32'(bus4.busy), 32'h0);
    chk("arst_grant", 32'(bus4.grant), 32'h0);
    chk("arst_odata", bus4.o_data, 32'h0);
    chk("arst_ready", 32'(bus4.req_ready), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive4(4'hF, 4'h0, 8'h90, 1'b1);
    #2;
    chk("post_rst_ready", 32'(bus4.req_ready), 32'h1);
    @(posedge clk); #1;
    chk("post_rst_odata", bus4.o_data, 32'h90);
    chk("post_rst_busy", 32'(bus4.busy), 32'h0);
    drive4(4'h0, 4'h0, 8'h00, 1'b1);

    // Non-power-of-2: three requesters, pointer must wrap 2 -> 0.
    bus3.req_valid = 3'b111;
    bus3.req_lock  = 3'b000;
    for (int k = 0; k < 3; k++) bus3.req_data[k*32 +: 32] = 32'hC0 + 32'(k);
    for (int s = 0; s < 4; s++) begin
      logic [2:0] er;
      logic [31:0] ed;
      er = (s == 3) ? 3'b001 : 3'(1 << s);
      ed = (s == 3) ? 32'hC0 : 32'hC0 + 32'(s);
      #2;
      chk($sformatf("n3_ready%0d", s), 32'(bus3.req_ready), 32'(er));
      @(posedge clk); #1;
      chk($sformatf("n3_odata%0d", s), bus3.o_data, ed);
      chk($sformatf("n3_ovalid%0d", s), 32'(bus3.o_valid), 32'h1);
    end
    bus3.req_valid = '0;
    @(posedge clk); #1;
    chk("n3_idle_ovalid", 32'(bus3.o_valid), 32'h0);
    chk("n3_idle_odata", bus3.o_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
